// File: rtl/load_store_align.sv
// Memory-stage load/store alignment unit: byte-lane steering, req/ack memory access,
// load extraction with sign/zero extension, and misaligned/illegal/timeout fault reporting.
module load_store_align #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        legal, aligned, accept, timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, ext_data;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic [15:0] cnt;

  always_comb begin
    legal   = op_valid & (op_load ^ op_store) & (op_size != 2'b11);
    aligned = 1'b1;
    case (op_size)
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept      = (state == IDLE) & legal & aligned;
    stall       = (state == REQ) | accept;
    timeout_hit = (state == REQ) & ~mem_ack & (cnt == CNT_LAST);
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    case (op_size)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
      end
    endcase
  end

  // Lane selection uses the offset captured at accept; addr may change while stalled.
  always_comb begin
    rbyte    = mem_rdata[{off_q, 3'b000} +: 8];
    rhalf    = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ext_data = mem_rdata;
    case (size_q)
      2'b00:   ext_data = unsigned_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ext_data = unsigned_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_ack || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
      load_valid <= 1'b0;
      load_data  <= 32'h0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      cnt        <= 16'h0;
    end else begin
      fault      <= 1'b0;
      load_valid <= 1'b0;
      if (state == IDLE) begin
        // Illegal encoding is checked first so it wins over misalignment.
        if (op_valid && !legal) begin
          fault      <= 1'b1;
          fault_code <= 2'b11;
        end else if (op_valid && !aligned) begin
          fault      <= 1'b1;
          fault_code <= 2'b01;
        end else if (accept) begin
          mem_req    <= 1'b1;
          mem_we     <= op_store;
          mem_addr   <= {addr[31:2], 2'b00};
          mem_be     <= be_nxt;
          mem_wdata  <= wdata_nxt;
          size_q     <= op_size;
          unsigned_q <= op_unsigned;
          off_q      <= addr[1:0];
          cnt        <= 16'h0;
        end
      end else begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) begin
            load_valid <= 1'b1;
            load_data  <= ext_data;
          end
        end else begin
          cnt <= cnt + 16'h1;
          if (timeout_hit) begin
            mem_req    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= 2'b10;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_align.sv
// Randomized and directed bench for load_store_align; expectations come from a
// byte-arithmetic reference model of the alignment and extension rules.
module tb_load_store_align;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_load, op_store, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  load_store_align #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_load(op_load),
    .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
    .addr(addr), .store_data(store_data), .stall(stall),
    .load_valid(load_valid), .load_data(load_data), .fault(fault),
    .fault_code(fault_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation presented at the current cycle; waits = cycles before ack, ack_en=0 forces timeout.
  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int waits, input bit ack_en);
    bit ill, mis, acked, tmo;
    int nbytes, off;
    logic [31:0] e_be, e_wdata, mask, v;
    ill = (ld == st) || (sz == 2'b11);
    mis = !ill && ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off    = (sz == 2'b10) ? 0 : (sz == 2'b01) ? int'(a & 32'h2) : int'(a & 32'h3);
    e_be   = ((32'h1 << nbytes) - 1) << off;
    e_wdata = (sz == 2'b00) ? (sd & 32'hFF) * 32'h01010101 :
              (sz == 2'b01) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
    v = (rd >> (8 * off)) & mask;
    if (!uns && nbytes != 4 && v[8 * nbytes - 1]) v = v | ~mask;

    op_valid = 1'b1; op_load = ld; op_store = st; op_size = sz;
    op_unsigned = uns; addr = a; store_data = sd;
    #1;
    chk("stall_accept", {31'h0, stall}, {31'h0, !(ill || mis)});
    tick();
    op_valid = 1'b0; addr = $urandom; store_data = $urandom; op_size = 2'($urandom);
    if (ill || mis) begin
      chk("reject_fault", {31'h0, fault}, 32'h1);
      chk("reject_code", {30'h0, fault_code}, ill ? 32'h3 : 32'h1);
      chk("reject_req", {31'h0, mem_req}, 32'h0);
      chk("reject_stall", {31'h0, stall}, 32'h0);
      return;
    end
    acked = 1'b0; tmo = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      chk("req_high", {31'h0, mem_req}, 32'h1);
      chk("req_stall", {31'h0, stall}, 32'h1);
      chk("req_we", {31'h0, mem_we}, {31'h0, st});
      chk("req_addr", mem_addr, a & ~32'h3);
      chk("req_be", {28'h0, mem_be}, e_be);
      if (st) chk("req_wdata", mem_wdata, e_wdata);
      chk("req_no_pulse", {30'h0, load_valid, fault}, 32'h0);
      if (ack_en && k == waits + 1) begin
        mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (k == TO) tmo = 1'b1;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (acked || tmo) break;
    end
    chk("done_req", {31'h0, mem_req}, 32'h0);
    chk("done_stall", {31'h0, stall}, 32'h0);
    chk("done_lvalid", {31'h0, load_valid}, {31'h0, acked && ld});
    chk("done_fault", {31'h0, fault}, {31'h0, tmo});
    if (tmo) chk("timeout_code", {30'h0, fault_code}, 32'h2);
    if (acked && ld) chk("load_data", load_data, v);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_size = 2'b00;
    op_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_outs", {mem_req, mem_we, load_valid, fault, stall}, 32'h0);
    chk("rst_be_code", {26'h0, mem_be, fault_code}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ldata", load_data, 32'h0);

    do_op(1, 0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1);   // LB, zero wait
    do_op(1, 0, 2'b01, 1, 32'h2002, 32'h0, 32'h9ABC_5678, 3, 1);   // LHU, ack ties timeout count
    do_op(0, 1, 2'b00, 0, 32'h31, 32'h0000_00A5, 32'h0, 1, 1);     // SB
    do_op(0, 1, 2'b01, 0, 32'h32, 32'h0000_BEEF, 32'h0, 0, 1);     // SH
    do_op(1, 0, 2'b10, 0, 32'h6, 32'h0, 32'h0, 0, 1);              // misaligned LW
    do_op(1, 1, 2'b10, 0, 32'h8, 32'h0, 32'h0, 0, 1);              // load=store=1
    do_op(0, 0, 2'b00, 0, 32'h8, 32'h0, 32'h0, 0, 1);              // load=store=0
    do_op(1, 0, 2'b11, 0, 32'h8, 32'h0, 32'h0, 0, 1);              // size 11
    do_op(1, 1, 2'b10, 0, 32'h6, 32'h0, 32'h0, 0, 1);              // illegal beats misaligned
    do_op(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 0);             // LW timeout

    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    chk("late_ack_ignored", {29'h0, mem_req, load_valid, fault}, 32'h0);
    mem_ack = 1'b0;

    // Reset in the second REQ cycle of a word load.
    op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_size = 2'b10; addr = 32'h100;
    tick();
    op_valid = 1'b0;
    tick();
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outs", {mem_req, mem_we, load_valid, fault, stall}, 32'h0);
    chk("midrst_be", {28'h0, mem_be}, 32'h0);
    chk("midrst_addr", mem_addr, 32'h0);
    tick();
    chk("midrst_quiet", {30'h0, load_valid, fault}, 32'h0);
    do_op(1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h1357_9BDF, 2, 1);

    for (int i = 0; i < 80; i++) begin
      bit ld, st;
      int kind;
      kind = int'($urandom_range(0, 9));
      ld = $urandom_range(0, 1) == 1;
      st = (kind == 0) ? ld : !ld;
      do_op(ld, st, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            int'($urandom_range(0, TO - 1)), kind != 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_align.md
# load_store_align

Memory-stage load/store alignment unit for the pipelined MIPS core. It narrows store data onto byte lanes with byte enables and issues word-aligned requests to data memory over a req/ack handshake. It selects the addressed byte or halfword from returned load data and sign- or zero-extends it to 32 bits. It stalls the pipeline while an access is outstanding and reports misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT, 255: maximum cycles in REQ without mem_ack before a bus fault (1..65535).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  memory operation present this cycle.
- op_load  in  1  operation is a load.
- op_store  in  1  operation is a store.
- op_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- op_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for words and stores.
- addr  in  32  byte address.
- store_data  in  32  store operand; low bits are used for byte and halfword stores.
- stall  out  1  freeze upstream pipeline.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- load_data  out  32  extended load result.
- fault  out  1  one-cycle pulse on an error.
- fault_code  out  2  01 misaligned, 10 timeout, 11 illegal encoding.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_be  out  4  byte enables; bit k covers bits [8k+7:8k].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data; valid when mem_ack is high.
- mem_ack  in  1  request complete.

## Operation
- States: IDLE, REQ. All outputs are registered except stall.
- Accept condition: IDLE, op_valid, and exactly one of op_load/op_store set, op_size≠11, access aligned.
- Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
- Illegal encoding: op_valid with load=store (both 0 or both 1) or op_size=11. Result: fault=1 and code 11 on the next cycle. No memory access, no stall.
- Misaligned access: fault=1 and code 01 on the next cycle. No memory access, no stall.
- Illegal encoding takes priority over misalignment.
- On accept, the unit latches mem_we, mem_addr, mem_be, mem_wdata, size, unsigned flag and addr[1:0], then enters REQ.
- Byte store: mem_be=1<<addr[1:0]; mem_wdata={4{store_data[7:0]}}.
- Halfword store: mem_be=0011 if addr[1]=0, else 1100; mem_wdata={2{store_data[15:0]}}.
- Word store: mem_be=1111; mem_wdata=store_data. Loads drive the same mem_be pattern.
- Load extract: byte = rdata[8k+7:8k] with k=addr[1:0]; halfword = rdata[16h+15:16h] with h=addr[1]. Sign-extend from the top bit, or zero-extend if op_unsigned. Word loads pass through unchanged.
- In REQ, all mem_* outputs are held stable until mem_ack is sampled high.
- On ack: mem_req drops at the next edge and the unit returns to IDLE. For a load, load_data is registered and load_valid pulses.
- Timeout: a 16-bit counter clears on accept and increments each REQ cycle without ack. When it reaches TIMEOUT, mem_req drops, fault=1 with code 10, the unit returns to IDLE and load_valid is not asserted.
- If ack and timeout occur in the same cycle, ack wins.
- mem_ack sampled in IDLE is ignored.
- stall = (state==REQ) | accept condition.
- A new op can be accepted in the cycle after return to IDLE.

## Timing
- Reset values: state IDLE; mem_req, mem_we, load_valid, fault = 0; mem_be=0000; mem_addr, mem_wdata, load_data = 0; fault_code=00; counter=0.
- Reset during REQ drops mem_req at that edge. No fault is raised and no load_valid is issued.
- Cycle 0: accept, stall=1.
- Cycle 1: mem_req=1.
- Ack in cycle n (n≥1): stall=1 through cycle n; cycle n+1: mem_req=0, stall=0, and load_valid=1 for loads.
- Minimum load or store latency is 2 cycles (zero-wait memory acks in cycle 1).
- Fault pulses appear 1 cycle after a rejected op, or the cycle after the timeout count is reached.

## Test plan
- LB at addr 0x1003, mem_rdata=0x80FF_1234, ack in cycle 1 -> mem_be=1000; load_data=0xFFFFFF80 with load_valid at cycle 2.
- LHU at addr 0x2002, mem_rdata=0x9ABC_5678, ack after 3 wait cycles -> mem_req held with stable outputs for cycles 1..4; load_data=0x00009ABC; stall low at cycle 5.
- SB of 0x000000A5 at addr 0x31; SH of 0x0000BEEF at addr 0x32 -> SB: mem_be=0010, mem_wdata=0xA5A5A5A5. SH: mem_be=1100, mem_wdata=0xBEEFBEEF. mem_we=1 for both.
- LW at addr 0x6 -> fault=1, fault_code=01, mem_req never asserts, stall=0. An op with load=store=1 -> fault_code=11.
- LW with TIMEOUT=4 and no ack -> mem_req high 4 cycles then low; fault_code=10; no load_valid. A later ack is ignored.
- Reset asserted in the 2nd REQ cycle -> mem_req=0 after that edge, all outputs at reset values, and the next LW completes normally.
